// File: rtl/masked_compare_eq.sv
// ============================================================================
// Module      : masked_compare_eq (with helper gadget masked_compare_eq_or_hpc2)
// Description : Pipelined d-share masked equality / inequality comparator
//               built from a chain of HPC2 masked OR gadgets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module masked_compare_eq_or_hpc2 #(
    parameter int D = 2
) (
    input  logic                   clk,
    input  logic [D-1:0]           i_ina,
    input  logic [D-1:0]           i_inb,
    input  logic [D*(D-1)/2-1:0]   i_rnd,
    output logic [D-1:0]           o_out
);

    localparam int C_NRND = D * (D - 1) / 2;

    // Index of the shared random bit r_ij = r_ji for the unordered pair (i, j).
    function automatic int pidx(input int i, input int j);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * D - (lo * (lo + 1)) / 2 + (hi - lo - 1);
    endfunction

    logic [D-1:0]      w_a;
    logic [D-1:0]      w_b;
    logic [D-1:0]      w_and;

    logic [D-1:0]      r_b;
    logic [C_NRND-1:0] r_rnd;
    logic [D-1:0]      r_v [D];
    logic [D-1:0]      r_ab;
    logic [D-1:0]      r_u [D];
    logic [D-1:0]      r_w [D];

    // OR is computed as NOT(AND(NOT a, NOT b)); masked NOT flips share 0 only.
    always_comb begin
        w_a    = i_ina;
        w_a[0] = ~i_ina[0];
        w_b    = i_inb;
        w_b[0] = ~i_inb[0];
    end

    // inb stage: b is blinded with fresh randomness before it meets a.
    always_ff @(posedge clk) begin
        r_b   <= w_b;
        r_rnd <= i_rnd;
        for (int i = 0; i < D; i++) begin
            for (int j = 0; j < D; j++) begin
                if (i != j) begin
                    r_v[i][j] <= w_b[j] ^ i_rnd[pidx(i, j)];
                end else begin
                    r_v[i][j] <= 1'b0;
                end
            end
        end
    end

    // ina stage: every cross-share product lands in its own register.
    always_ff @(posedge clk) begin
        for (int i = 0; i < D; i++) begin
            r_ab[i] <= w_a[i] & r_b[i];
            for (int j = 0; j < D; j++) begin
                if (i != j) begin
                    r_u[i][j] <= ~w_a[i] & r_rnd[pidx(i, j)];
                    r_w[i][j] <= w_a[i] & r_v[i][j];
                end else begin
                    r_u[i][j] <= 1'b0;
                    r_w[i][j] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_and = '0;
        for (int i = 0; i < D; i++) begin
            w_and[i] = r_ab[i];
            for (int j = 0; j < D; j++) begin
                w_and[i] = w_and[i] ^ r_u[i][j] ^ r_w[i][j];
            end
        end
    end

    always_comb begin
        o_out    = w_and;
        o_out[0] = ~w_and[0];
    end

endmodule

module masked_compare_eq #(
    parameter int D     = 2,
    parameter int WIDTH = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic                              in_mode,
    input  logic [D*WIDTH-1:0]                a_input,
    input  logic [D*WIDTH-1:0]                b_input,
    input  logic [(WIDTH-1)*(D*(D-1)/2)-1:0]  rnd,
    output logic                              out_valid,
    output logic [D-1:0]                      out_result,
    output logic                              busy
);

    localparam int C_NRND = D * (D - 1) / 2;

    logic [D*WIDTH-1:0] w_diff;
    logic [D-1:0]       w_dly [WIDTH];
    logic [D-1:0]       w_g   [WIDTH-1];
    logic [D-1:0]       w_neq;
    logic [D-1:0]       w_res;
    logic [WIDTH-1:0]   r_vld;
    logic [WIDTH-1:0]   r_mode;

    assign w_diff = a_input ^ b_input;

    // diff_0 feeds gadget 0 as ina (one cycle late); diff_i feeds gadget i-1 as inb.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        localparam int C_DLY = (gi == 0) ? 1 : gi - 1;
        if (C_DLY == 0) begin : g_direct
            assign w_dly[gi] = w_diff[D*gi +: D];
        end else begin : g_line
            logic [D-1:0] r_line [C_DLY];
            always_ff @(posedge clk) begin
                r_line[0] <= w_diff[D*gi +: D];
                for (int k = 1; k < C_DLY; k++) begin
                    r_line[k] <= r_line[k-1];
                end
            end
            assign w_dly[gi] = r_line[C_DLY-1];
        end
    end

    for (genvar gk = 0; gk < WIDTH - 1; gk++) begin : g_gadget
        logic [D-1:0] w_ina;
        if (gk == 0) begin : g_first
            assign w_ina = w_dly[0];
        end else begin : g_chain
            assign w_ina = w_g[gk-1];
        end
        masked_compare_eq_or_hpc2 #(
            .D (D)
        ) u_or (
            .clk   (clk),
            .i_ina (w_ina),
            .i_inb (w_dly[gk+1]),
            .i_rnd (rnd[C_NRND*gk +: C_NRND]),
            .o_out (w_g[gk])
        );
    end

    assign w_neq = w_g[WIDTH-2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= '0;
            r_mode <= '0;
        end else begin
            r_vld  <= {r_vld[WIDTH-2:0], in_valid};
            r_mode <= {r_mode[WIDTH-2:0], in_mode};
        end
    end

    // Shares are gated to zero on bubbles so stale masked data never leaves.
    always_comb begin
        w_res = '0;
        if (r_vld[WIDTH-1]) begin
            w_res    = w_neq;
            w_res[0] = w_neq[0] ^ r_mode[WIDTH-1];
        end
    end

    assign out_result = w_res;
    assign out_valid  = r_vld[WIDTH-1];
    assign busy       = |r_vld;

endmodule

`default_nettype wire
